// File: rtl/rmii_pkg.sv
// Shared types and constants for the RMII receive-side Ethernet/IPv4/UDP parser.
// The header struct is laid out so that wire byte n occupies bits [8n +: 8]:
// members are declared last-on-wire first, and element [0] of every
// multi-byte field is the first byte seen on the wire.
package rmii_pkg;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam int          HDR_BYTES     = 42;

  typedef enum logic [1:0] {
    HDR,
    PAY,
    DROP
  } rx_state_e;

  typedef struct packed {
    logic [1:0][7:0] checksum;
    logic [1:0][7:0] length;
    logic [1:0][7:0] dst_port;
    logic [1:0][7:0] src_port;
  } udp_header_t;

  typedef struct packed {
    logic [3:0][7:0] dst_ip;
    logic [3:0][7:0] src_ip;
    logic [1:0][7:0] header_checksum;
    logic [7:0]      protocol;
    logic [7:0]      ttl;
    logic [1:0][7:0] flags_fragment_offset;
    logic [1:0][7:0] identification;
    logic [1:0][7:0] total_length;
    logic [7:0]      dscp_ecn;
    logic [7:0]      version_ihl;
  } ipv4_header_t;

  typedef struct packed {
    logic [1:0][7:0] eth_type_length;
    logic [5:0][7:0] src_mac;
    logic [5:0][7:0] dst_mac;
  } eth_header_t;

  typedef struct packed {
    udp_header_t  udp;
    ipv4_header_t ip;
    eth_header_t  eth;
  } ethernet_header_t;

  // Network byte order: element [0] is the most significant byte.
  function automatic logic [15:0] be16(input logic [1:0][7:0] f);
    return {f[0], f[1]};
  endfunction

endpackage

// File: rtl/rmii_udp_rx_parser_csum.sv
// Byte-wise 16-bit one's-complement accumulator for the IPv4 header checksum.
// Bytes alternate high/low within each 16-bit word; the end-around carry is
// folded back on every byte so the running sum is always a valid 16-bit value.
module ipv4_csum_acc (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_hi,
  input  logic [7:0]  i_data,
  output logic [15:0] o_sum
);

  logic [15:0] r_sum;
  logic [15:0] w_base;
  logic [15:0] w_addend;
  logic [16:0] w_raw;

  assign w_base   = i_clear ? 16'h0000 : r_sum;
  assign w_addend = i_hi ? {i_data, 8'h00} : {8'h00, i_data};
  assign w_raw    = {1'b0, w_base} + {1'b0, w_addend};

  // Add the next byte into the running sum, folding the carry back in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= 16'h0000;
    end else if (i_en) begin
      r_sum <= w_raw[15:0] + {15'd0, w_raw[16]};
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/rmii_udp_rx_parser.sv
// Receive-side Ethernet/IPv4/UDP parser. Captures the 42-byte header, filters
// for IPv4/UDP frames addressed to this station and forwards only the UDP
// payload; Ethernet padding and rejected frames are discarded.
// Optional build macro RMII_RX_CSUM_CHECK_EN adds IPv4 header checksum
// verification to the filter.
module rmii_udp_rx_parser
  import rmii_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001,
  parameter int          CNT_W     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [7:0]                          s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [7:0]                          m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser,
  input  logic                                m_axis_tready,
  output logic [$bits(ethernet_header_t)-1:0] hdr_o,
  output logic                                hdr_valid_o,
  output logic [CNT_W-1:0]                    frames_ok_o,
  output logic [CNT_W-1:0]                    frames_drop_o
);

  rx_state_e        r_state;
  rx_state_e        w_next_state;
  ethernet_header_t r_hdr;
  logic [5:0]       r_byte_cnt;
  logic [15:0]      r_pay_cnt;
  logic [7:0]       r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_m_user;
  logic             r_hdr_valid;
  logic [CNT_W-1:0] r_frames_ok;
  logic [CNT_W-1:0] r_frames_drop;

  logic        w_accept;
  logic        w_hdr_last;
  logic        w_pay_last;
  logic        w_pay_load;
  logic        w_frame_ok;
  logic        w_frame_drop;
  logic        w_filter_pass;
  logic        w_csum_ok;
  logic [15:0] w_udp_len;
  logic [15:0] w_tot_len;
  logic [15:0] w_frag;
  logic [47:0] w_dst_mac;
  logic [31:0] w_dst_ip;

  assign s_axis_tready = (r_state == PAY) ? (!r_m_valid || m_axis_tready) : 1'b1;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_hdr_last    = (r_byte_cnt == 6'(HDR_BYTES - 1));
  assign w_pay_last    = (r_pay_cnt == 16'd1);

  // Byte 41 is the UDP checksum, which the filter never looks at, so the
  // registered header already holds everything needed when byte 41 arrives.
  assign w_udp_len = be16(r_hdr.udp.length);
  assign w_tot_len = be16(r_hdr.ip.total_length);
  assign w_frag    = be16(r_hdr.ip.flags_fragment_offset);
  assign w_dst_mac = {r_hdr.eth.dst_mac[0], r_hdr.eth.dst_mac[1], r_hdr.eth.dst_mac[2],
                      r_hdr.eth.dst_mac[3], r_hdr.eth.dst_mac[4], r_hdr.eth.dst_mac[5]};
  assign w_dst_ip  = {r_hdr.ip.dst_ip[0], r_hdr.ip.dst_ip[1],
                      r_hdr.ip.dst_ip[2], r_hdr.ip.dst_ip[3]};

`ifdef RMII_RX_CSUM_CHECK_EN
  logic [15:0] w_csum_sum;
  logic        w_csum_en;

  assign w_csum_en = (r_state == HDR) && w_accept &&
                     (r_byte_cnt >= 6'd14) && (r_byte_cnt <= 6'd33);

  ipv4_csum_acc u_csum (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_clear (r_byte_cnt == 6'd14),
    .i_en    (w_csum_en),
    .i_hi    (!r_byte_cnt[0]),
    .i_data  (s_axis_tdata),
    .o_sum   (w_csum_sum)
  );

  assign w_csum_ok = (w_csum_sum == 16'hFFFF);
`else
  assign w_csum_ok = 1'b1;
`endif

  // MF bit and fragment offset live in the low 14 bits; DF is allowed.
  assign w_filter_pass = (be16(r_hdr.eth.eth_type_length) == ETH_TYPE_IPV4) &&
                         (r_hdr.ip.version_ihl == IPV4_VER_IHL) &&
                         (r_hdr.ip.protocol == IP_PROTO_UDP) &&
                         ((w_dst_mac == LOCAL_MAC) || (w_dst_mac == 48'hFFFF_FFFF_FFFF)) &&
                         (w_dst_ip == LOCAL_IP) &&
                         ((w_frag & 16'h3FFF) == 16'h0000) &&
                         (w_udp_len > 16'd8) &&
                         (w_udp_len <= w_tot_len - 16'd20) &&
                         w_csum_ok;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-frame event strobes for the datapath.
  always_comb begin
    w_next_state = r_state;
    w_pay_load   = 1'b0;
    w_frame_ok   = 1'b0;
    w_frame_drop = 1'b0;
    case (r_state)
      HDR: begin
        if (w_accept) begin
          if (w_hdr_last) begin
            if (w_filter_pass && !s_axis_tlast) begin
              w_pay_load   = 1'b1;
              w_next_state = PAY;
            end else begin
              w_frame_drop = 1'b1;
              w_next_state = s_axis_tlast ? HDR : DROP;
            end
          end else if (s_axis_tlast) begin
            w_frame_drop = 1'b1;
          end
        end
      end
      PAY: begin
        if (w_accept) begin
          if (w_pay_last) begin
            w_frame_ok   = 1'b1;
            w_next_state = s_axis_tlast ? HDR : DROP;
          end else if (s_axis_tlast) begin
            w_frame_drop = 1'b1;
            w_next_state = HDR;
          end
        end
      end
      DROP: begin
        if (w_accept && s_axis_tlast) begin
          w_next_state = HDR;
        end
      end
      default: w_next_state = HDR;
    endcase
  end

  // Header capture, payload counting, output register and status counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hdr         <= '0;
      r_byte_cnt    <= 6'd0;
      r_pay_cnt     <= 16'd0;
      r_m_data      <= 8'h00;
      r_m_valid     <= 1'b0;
      r_m_last      <= 1'b0;
      r_m_user      <= 1'b0;
      r_hdr_valid   <= 1'b0;
      r_frames_ok   <= '0;
      r_frames_drop <= '0;
    end else begin
      r_hdr_valid <= w_pay_load;

      if ((r_state == HDR) && w_accept) begin
        for (int n = 0; n < HDR_BYTES; n++) begin
          if (r_byte_cnt == 6'(n)) begin
            r_hdr[8*n +: 8] <= s_axis_tdata;
          end
        end
        r_byte_cnt <= (w_hdr_last || s_axis_tlast) ? 6'd0 : r_byte_cnt + 6'd1;
      end

      if (w_pay_load) begin
        r_pay_cnt <= w_udp_len - 16'd8;
      end else if ((r_state == PAY) && w_accept) begin
        r_pay_cnt <= r_pay_cnt - 16'd1;
      end

      if ((r_state == PAY) && w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_axis_tdata;
        r_m_last  <= w_pay_last || s_axis_tlast;
        r_m_user  <= !w_pay_last && s_axis_tlast;
      end else if (m_axis_tready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_m_user  <= 1'b0;
      end

      if (w_frame_ok && (r_frames_ok != {CNT_W{1'b1}})) begin
        r_frames_ok <= r_frames_ok + CNT_W'(1);
      end
      if (w_frame_drop && (r_frames_drop != {CNT_W{1'b1}})) begin
        r_frames_drop <= r_frames_drop + CNT_W'(1);
      end
    end
  end

  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tuser  = r_m_user;
  assign hdr_o         = r_hdr;
  assign hdr_valid_o   = r_hdr_valid;
  assign frames_ok_o   = r_frames_ok;
  assign frames_drop_o = r_frames_drop;

endmodule

// File: tb/tb_rmii_udp_rx_parser.sv
// Directed testbench for rmii_udp_rx_parser. Frames are assembled byte by byte
// with a locally computed IPv4 checksum so they are valid with or without
// RMII_RX_CSUM_CHECK_EN; expected payload beats and counters are hand-derived.
module tb_rmii_udp_rx_parser;

  logic         clk;
  logic         rst_i;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic [7:0]   m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tuser;
  logic         m_axis_tready;
  logic [335:0] hdr_o;
  logic         hdr_valid_o;
  logic [15:0]  frames_ok_o;
  logic [15:0]  frames_drop_o;

  rmii_udp_rx_parser dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .hdr_o         (hdr_o),
    .hdr_valid_o   (hdr_valid_o),
    .frames_ok_o   (frames_ok_o),
    .frames_drop_o (frames_drop_o)
  );

  int         checkCount = 0;
  int         errorCount = 0;
  int         hdrValidCount = 0;
  int         stallCount = 0;
  int         ruleSamples = 0;
  int         ruleErrors = 0;
  bit         toggleReady = 0;
  bit         inPayload = 0;
  logic [7:0] txq[$];
  logic [7:0] rxData[$];
  bit         rxLast[$];
  bit         rxUser[$];
  logic [7:0] expData[$];
  bit         expLast[$];
  bit         expUser[$];
  int         expOk = 0;
  int         expDrop = 0;
  int         expHdrValid = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready: steady high, or alternating every cycle when requested.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggleReady) m_axis_tready = ~m_axis_tready;
      else             m_axis_tready = 1'b1;
    end
  end

  // Monitor on the falling edge: inputs are stable, so valid&&ready here is
  // exactly the transfer that happens at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (m_axis_tvalid && m_axis_tready) begin
          rxData.push_back(m_axis_tdata);
          rxLast.push_back(m_axis_tlast);
          rxUser.push_back(m_axis_tuser);
        end
        if (hdr_valid_o) hdrValidCount++;
        if (s_axis_tvalid && !s_axis_tready) stallCount++;
        if (inPayload && s_axis_tvalid) begin
          ruleSamples++;
          if (s_axis_tready !== (!m_axis_tvalid || m_axis_tready)) ruleErrors++;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Assemble a 42-byte header into txq with a valid IPv4 header checksum.
  task automatic buildHeader(input logic [47:0] mac, input logic [31:0] ip, input logic [15:0] etype,
                             input logic [15:0] ulen, input logic [15:0] tlen);
    logic [31:0] sum;
    logic [15:0] csum;
    txq.delete();
    for (int i = 5; i >= 0; i--) txq.push_back(mac[8*i +: 8]);
    txq.push_back(8'h02); txq.push_back(8'h00); txq.push_back(8'h00);
    txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h99);
    txq.push_back(etype[15:8]); txq.push_back(etype[7:0]);
    txq.push_back(8'h45); txq.push_back(8'h00);
    txq.push_back(tlen[15:8]); txq.push_back(tlen[7:0]);
    txq.push_back(8'h12); txq.push_back(8'h34);
    txq.push_back(8'h40); txq.push_back(8'h00);
    txq.push_back(8'h40); txq.push_back(8'h11);
    txq.push_back(8'h00); txq.push_back(8'h00);
    txq.push_back(8'hC0); txq.push_back(8'hA8); txq.push_back(8'h00); txq.push_back(8'h02);
    for (int i = 3; i >= 0; i--) txq.push_back(ip[8*i +: 8]);
    txq.push_back(8'h04); txq.push_back(8'hD2);
    txq.push_back(8'h16); txq.push_back(8'h2E);
    txq.push_back(ulen[15:8]); txq.push_back(ulen[7:0]);
    txq.push_back(8'hAB); txq.push_back(8'hCD);
    sum = 32'd0;
    for (int i = 14; i < 34; i += 2) sum += {16'd0, txq[i], txq[i+1]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
    csum = ~sum[15:0];
    txq[24] = csum[15:8];
    txq[25] = csum[7:0];
  endtask

  // Drive the first nBytes of txq, tlast on the final one, honouring tready.
  task automatic applyStimulus(input int nBytes);
    bit rdy;
    int budget;
    for (int i = 0; i < nBytes; i++) begin
      s_axis_tdata  = txq[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == nBytes - 1);
      inPayload     = (i >= 42);
      budget = 0;
      do begin
        @(negedge clk);
        rdy = s_axis_tready;
        @(posedge clk);
        #1;
        budget++;
      end while (!rdy && budget < 200);
      if (!rdy) begin
        checkOutput("input_timeout", 32'(i), 32'hFFFF_FFFF);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    inPayload     = 0;
    toggleReady   = 0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic expectBeat(input logic [7:0] d, input bit l, input bit u);
    expData.push_back(d);
    expLast.push_back(l);
    expUser.push_back(u);
  endtask

  task automatic checkBeats(input string tag);
    checkOutput({tag, "_beats"}, 32'(rxData.size()), 32'(expData.size()));
    for (int i = 0; i < expData.size() && i < rxData.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, rxData[i]}, {24'd0, expData[i]});
      checkOutput($sformatf("%s_last%0d", tag, i), {31'd0, rxLast[i]}, {31'd0, expLast[i]});
      checkOutput($sformatf("%s_user%0d", tag, i), {31'd0, rxUser[i]}, {31'd0, expUser[i]});
    end
    checkOutput({tag, "_ok"}, {16'd0, frames_ok_o}, 32'(expOk));
    checkOutput({tag, "_drop"}, {16'd0, frames_drop_o}, 32'(expDrop));
    checkOutput({tag, "_hdrvalid"}, 32'(hdrValidCount), 32'(expHdrValid));
    rxData.delete(); rxLast.delete(); rxUser.delete();
    expData.delete(); expLast.delete(); expUser.delete();
  endtask

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] IP  = 32'hC0A8_0001;

  initial begin
    rst_i         = 1'b1;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tready", {31'd0, s_axis_tready}, 32'd1);
    checkOutput("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
    checkOutput("rst_hdrvalid", {31'd0, hdr_valid_o}, 32'd0);
    checkOutput("rst_hdr", {31'd0, |hdr_o}, 32'd0);
    checkOutput("rst_ok", {16'd0, frames_ok_o}, 32'd0);
    checkOutput("rst_drop", {16'd0, frames_drop_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    $display("[TB] basic frame");
    buildHeader(MAC, IP, 16'h0800, 16'h000C, 16'd32);
    txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); txq.push_back(8'h44);
    applyStimulus(txq.size());
    expectBeat(8'h11, 0, 0); expectBeat(8'h22, 0, 0);
    expectBeat(8'h33, 0, 0); expectBeat(8'h44, 1, 0);
    expOk = 1; expHdrValid = 1;
    checkBeats("basic");
    checkOutput("hdr_byte0", {24'd0, hdr_o[7:0]}, 32'h02);
    checkOutput("hdr_byte12", {24'd0, hdr_o[103:96]}, 32'h08);
    checkOutput("hdr_byte39", {24'd0, hdr_o[319:312]}, 32'h0C);
    checkOutput("hdr_byte41", {24'd0, hdr_o[335:328]}, 32'hCD);

    $display("[TB] padded frame");
    buildHeader(MAC, IP, 16'h0800, 16'h000A, 16'd30);
    txq.push_back(8'hAA); txq.push_back(8'hBB);
    for (int i = 0; i < 16; i++) txq.push_back(8'(8'hE0 + i));
    stallCount = 0;
    applyStimulus(txq.size());
    checkOutput("pad_len", 32'(txq.size()), 32'd60);
    checkOutput("pad_stalls", 32'(stallCount), 32'd0);
    expectBeat(8'hAA, 0, 0); expectBeat(8'hBB, 1, 0);
    expOk = 2; expHdrValid = 2;
    checkBeats("pad");

    $display("[TB] ARP frame");
    buildHeader(MAC, IP, 16'h0806, 16'h000C, 16'd32);
    txq.push_back(8'h01); txq.push_back(8'h02); txq.push_back(8'h03); txq.push_back(8'h04);
    applyStimulus(txq.size());
    expDrop = 1;
    checkBeats("arp");

    $display("[TB] short frame then valid frame");
    buildHeader(MAC, IP, 16'h0800, 16'h000C, 16'd32);
    applyStimulus(21);
    expDrop = 2;
    checkBeats("short");
    buildHeader(MAC, IP, 16'h0800, 16'h000A, 16'd30);
    txq.push_back(8'h55); txq.push_back(8'h66);
    applyStimulus(txq.size());
    expectBeat(8'h55, 0, 0); expectBeat(8'h66, 1, 0);
    expOk = 3; expHdrValid = 3;
    checkBeats("after_short");

    $display("[TB] truncated payload");
    buildHeader(MAC, IP, 16'h0800, 16'h0010, 16'd36);
    txq.push_back(8'hC1); txq.push_back(8'hC2); txq.push_back(8'hC3);
    applyStimulus(txq.size());
    expectBeat(8'hC1, 0, 0); expectBeat(8'hC2, 0, 0); expectBeat(8'hC3, 1, 1);
    expDrop = 3; expHdrValid = 4;
    checkBeats("trunc");

    $display("[TB] backpressure");
    buildHeader(MAC, IP, 16'h0800, 16'h0010, 16'd36);
    for (int i = 1; i <= 8; i++) txq.push_back(8'(i));
    for (int i = 1; i <= 8; i++) expectBeat(8'(i), i == 8, 0);
    stallCount = 0; ruleSamples = 0; ruleErrors = 0;
    toggleReady = 1;
    applyStimulus(txq.size());
    expOk = 4; expHdrValid = 5;
    checkBeats("bp");
    checkOutput("bp_rule_errors", 32'(ruleErrors), 32'd0);
    checkOutput("bp_rule_sampled", {31'd0, ruleSamples > 0}, 32'd1);
    checkOutput("bp_stalled", {31'd0, stallCount > 0}, 32'd1);

    $display("[TB] boundary lengths");
    buildHeader(MAC, IP, 16'h0800, 16'h0008, 16'd28);
    applyStimulus(txq.size());
    expDrop = 4;
    checkBeats("udp8");
    buildHeader(MAC, IP, 16'h0800, 16'h000C, 16'd32);
    applyStimulus(txq.size());
    expDrop = 5;
    checkBeats("tlast41");
    buildHeader(MAC, IP, 16'h0800, 16'h000C, 16'd31);
    for (int i = 0; i < 4; i++) txq.push_back(8'h5A);
    applyStimulus(txq.size());
    expDrop = 6;
    checkBeats("udp_gt_ip");
    buildHeader(48'hFFFF_FFFF_FFFF, IP, 16'h0800, 16'h0009, 16'd29);
    txq.push_back(8'h77);
    applyStimulus(txq.size());
    expectBeat(8'h77, 1, 0);
    expOk = 5; expHdrValid = 6;
    checkBeats("bcast");
    buildHeader(48'h02_00_00_00_00_02, IP, 16'h0800, 16'h0009, 16'd29);
    txq.push_back(8'h78);
    applyStimulus(txq.size());
    expDrop = 7;
    checkBeats("wrong_mac");

`ifdef RMII_RX_CSUM_CHECK_EN
    $display("[TB] corrupted checksum");
    buildHeader(MAC, IP, 16'h0800, 16'h000A, 16'd30);
    txq.push_back(8'h90); txq.push_back(8'h91);
    txq[25] = txq[25] ^ 8'h01;
    applyStimulus(txq.size());
    expDrop = 8;
    checkBeats("csum");
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
